// File: rtl/btn_pkg.sv
// ============================================================================
// Module   : btn_pkg
// Brief    : Shared FSM state type, width helpers and default button parameters.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
`default_nettype none

package btn_pkg;

    typedef enum logic [1:0] {
        REL  = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } btn_state_t;

    localparam int c_def_nch        = 4;
    localparam int c_def_div        = 8;
    localparam int c_def_n          = 3;
    localparam int c_def_hold_ticks = 64;
    localparam int c_def_rpt_ticks  = 16;
    localparam int c_def_active_low = 0;

    // Bits needed for a counter that must be able to hold max_val itself.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce_ch.sv
// ============================================================================
// Module   : btn_debounce_ch
// Brief    : One button channel: synchroniser, tick-sampled stable filter and
//            press/hold/repeat state machine with registered pulse outputs.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
`default_nettype none

module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int N          = c_def_n,
    parameter int HOLD_TICKS = c_def_hold_ticks,
    parameter int RPT_TICKS  = c_def_rpt_ticks,
    parameter int ACTIVE_LOW = c_def_active_low
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int              c_cw   = cnt_width(N);
    localparam int              c_hw   = cnt_width(max2(HOLD_TICKS, RPT_TICKS));
    localparam logic [c_cw-1:0] c_n    = c_cw'(N);
    localparam logic [c_hw-1:0] c_hold = c_hw'(HOLD_TICKS);
    localparam logic [c_hw-1:0] c_rpt  = c_hw'(RPT_TICKS);

    logic            w_p;
    logic            r_sync1;
    logic            r_sync2;
    logic [c_cw-1:0] r_cnt;
    logic [c_cw-1:0] w_cnt_inc;
    logic            w_flip;
    logic            w_press_evt;
    logic            w_rel_evt;
    logic            r_level;
    logic            r_press;
    logic            r_release;
    logic            r_repeat;
    btn_state_t      r_state;
    logic [c_hw-1:0] r_hcnt;
    logic [c_hw-1:0] w_hcnt_inc;
    logic [c_hw-1:0] w_hcnt_tgt;

    assign w_p         = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_flip      = tick && (r_sync2 != r_level) && (w_cnt_inc == c_n);
    assign w_press_evt = w_flip && !r_level;
    assign w_rel_evt   = w_flip && r_level;
    assign w_hcnt_inc  = r_hcnt + 1'b1;
    assign w_hcnt_tgt  = (r_state == RPT) ? c_rpt : c_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= w_p;
            r_sync2 <= r_sync1;
        end
    end

    // Level only moves after N consecutive disagreeing ticks; any agreeing tick restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (tick) begin
                if (r_sync2 == r_level) begin
                    r_cnt <= '0;
                end else if (w_flip) begin
                    r_cnt     <= '0;
                    r_level   <= ~r_level;
                    r_press   <= w_press_evt;
                    r_release <= w_rel_evt;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    // Release outranks a repeat that would land on the same tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= REL;
            r_hcnt   <= '0;
            r_repeat <= 1'b0;
        end else begin
            r_repeat <= 1'b0;
            case (r_state)
                REL: begin
                    r_hcnt <= '0;
                    if (w_press_evt) begin
                        r_state <= HOLD;
                    end
                end
                HOLD, RPT: begin
                    if (w_rel_evt) begin
                        r_state <= REL;
                        r_hcnt  <= '0;
                    end else if (!repeat_en) begin
                        r_state <= HOLD;
                        r_hcnt  <= '0;
                    end else if (tick) begin
                        if (w_hcnt_inc == w_hcnt_tgt) begin
                            r_repeat <= 1'b1;
                            r_hcnt   <= '0;
                            r_state  <= RPT;
                        end else begin
                            r_hcnt <= w_hcnt_inc;
                        end
                    end
                end
                default: begin
                    r_state <= REL;
                    r_hcnt  <= '0;
                end
            endcase
        end
    end

    assign level         = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign repeat_pulse  = r_repeat;

endmodule

`default_nettype wire

// File: rtl/btn_debouncer_multi.sv
// ============================================================================
// Module   : btn_debouncer_multi
// Brief    : NCH-channel button debouncer with press, release and auto-repeat
//            pulses; one sample-tick divider shared by every channel.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
`default_nettype none

module btn_debouncer_multi
    import btn_pkg::*;
#(
    parameter int NCH        = c_def_nch,
    parameter int DIV        = c_def_div,
    parameter int N          = c_def_n,
    parameter int HOLD_TICKS = c_def_hold_ticks,
    parameter int RPT_TICKS  = c_def_rpt_ticks,
    parameter int ACTIVE_LOW = c_def_active_low
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] btn_raw,
    input  logic [NCH-1:0] repeat_en,
    output logic [NCH-1:0] level,
    output logic [NCH-1:0] press_pulse,
    output logic [NCH-1:0] release_pulse,
    output logic [NCH-1:0] repeat_pulse
);

    localparam int              c_dw   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_dw-1:0] c_last = c_dw'(DIV - 1);

    logic [c_dw-1:0] r_div;
    logic            w_tick;

    // With DIV=1 the counter sits at 0 and the tick is permanently high.
    assign w_tick = (r_div == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        btn_debounce_ch #(
            .N          (N),
            .HOLD_TICKS (HOLD_TICKS),
            .RPT_TICKS  (RPT_TICKS),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .tick          (w_tick),
            .btn_raw       (btn_raw[gi]),
            .repeat_en     (repeat_en[gi]),
            .level         (level[gi]),
            .press_pulse   (press_pulse[gi]),
            .release_pulse (release_pulse[gi]),
            .repeat_pulse  (repeat_pulse[gi])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_btn_debouncer_multi.sv
// ============================================================================
// Module   : tb_btn_debouncer_multi
// Brief    : Directed table-driven bench for btn_debouncer_multi (DIV=4, N=3,
//            HOLD_TICKS=8, RPT_TICKS=4).
// Revision : 1.0 - initial multi-channel release
// ============================================================================
`default_nettype none

module tb_btn_debouncer_multi;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic [3:0] repeat_en;
    logic [3:0] level;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] repeat_pulse;

    btn_debouncer_multi #(
        .NCH        (4),
        .DIV        (4),
        .N          (3),
        .HOLD_TICKS (8),
        .RPT_TICKS  (4),
        .ACTIVE_LOW (0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .repeat_en     (repeat_en),
        .level         (level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-segment pulse counts, one nibble per channel (nibble i = channel i).
    typedef struct packed {
        logic [3:0]  btn;
        logic [3:0]  ren;
        logic [7:0]  cyc;
        logic [3:0]  lvl;
        logic [15:0] prs;
        logic [15:0] rel;
        logic [15:0] rpt;
    } vec_t;

    vec_t tbl [10];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int wid_err = 0;
    int ovl_err = 0;
    int t_prs [4];
    int t_rel [4];
    int rpt_q [$];
    logic [3:0][3:0] n_prs;
    logic [3:0][3:0] n_rel;
    logic [3:0][3:0] n_rpt;
    logic [3:0] prv_prs = '0;
    logic [3:0] prv_rel = '0;
    logic [3:0] prv_rpt = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic clear_counts();
        n_prs = '0;
        n_rel = '0;
        n_rpt = '0;
        rpt_q.delete();
        for (int i = 0; i < 4; i++) begin
            t_prs[i] = -1;
            t_rel[i] = -1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (press_pulse[i]) begin
                n_prs[i] = n_prs[i] + 4'd1;
                t_prs[i] = cyc;
            end
            if (release_pulse[i]) begin
                n_rel[i] = n_rel[i] + 4'd1;
                t_rel[i] = cyc;
            end
            if (repeat_pulse[i]) begin
                n_rpt[i] = n_rpt[i] + 4'd1;
                if (i == 2) rpt_q.push_back(cyc);
            end
            if ((press_pulse[i] && prv_prs[i]) || (release_pulse[i] && prv_rel[i]) ||
                (repeat_pulse[i] && prv_rpt[i]))
                wid_err++;
            if ((press_pulse[i] && repeat_pulse[i]) || (press_pulse[i] && release_pulse[i]))
                ovl_err++;
        end
        prv_prs = press_pulse;
        prv_rel = release_pulse;
        prv_rpt = repeat_pulse;
    endtask

    task automatic wait_press(input int ch, input int lim, output int lat);
        int s;
        s   = cyc;
        lat = -1;
        for (int k = 0; k < lim && n_prs[ch] == 4'd0; k++) step();
        if (n_prs[ch] != 4'd0) lat = t_prs[ch] - s;
    endtask

    initial begin
        int lat;
        int p;
        int s0;
        string nm;

        // btn, ren, cycles, level at end, press / release / repeat counts
        tbl[0] = '{4'b0001, 4'hF, 8'd28,  4'b0001, 16'h0001, 16'h0000, 16'h0000};
        tbl[1] = '{4'b0000, 4'hF, 8'd28,  4'b0000, 16'h0000, 16'h0001, 16'h0000};
        tbl[2] = '{4'b1000, 4'hF, 8'd8,   4'b0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[3] = '{4'b0000, 4'hF, 8'd24,  4'b0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[4] = '{4'b0011, 4'hF, 8'd28,  4'b0011, 16'h0011, 16'h0000, 16'h0000};
        tbl[5] = '{4'b0000, 4'hF, 8'd28,  4'b0000, 16'h0000, 16'h0011, 16'h0000};
        tbl[6] = '{4'b0100, 4'hB, 8'd120, 4'b0100, 16'h0100, 16'h0000, 16'h0000};
        tbl[7] = '{4'b0100, 4'hF, 8'd28,  4'b0100, 16'h0000, 16'h0000, 16'h0000};
        tbl[8] = '{4'b0100, 4'hF, 8'd4,   4'b0100, 16'h0000, 16'h0000, 16'h0100};
        tbl[9] = '{4'b0000, 4'hF, 8'd28,  4'b0000, 16'h0000, 16'h0100, 16'h0000};

        clear_counts();
        rst_n     = 1'b0;
        btn_raw   = 4'hF;
        repeat_en = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {level, press_pulse, release_pulse, repeat_pulse}, 32'h0);
        btn_raw = 4'h0;
        rst_n   = 1'b1;
        repeat (8) step();
        chk("idle_outputs", {level, press_pulse, release_pulse, repeat_pulse}, 32'h0);

        for (int v = 0; v < 10; v++) begin
            btn_raw   = tbl[v].btn;
            repeat_en = tbl[v].ren;
            clear_counts();
            for (int k = 0; k < int'(tbl[v].cyc); k++) step();
            $sformat(nm, "vec%0d_level", v);
            chk(nm, {28'h0, level}, {28'h0, tbl[v].lvl});
            $sformat(nm, "vec%0d_press", v);
            chk(nm, {16'h0, n_prs}, {16'h0, tbl[v].prs});
            $sformat(nm, "vec%0d_release", v);
            chk(nm, {16'h0, n_rel}, {16'h0, tbl[v].rel});
            $sformat(nm, "vec%0d_repeat", v);
            chk(nm, {16'h0, n_rpt}, {16'h0, tbl[v].rpt});
        end

        // Auto-repeat cadence on ch2: first at +32, then every 16 cycles.
        clear_counts();
        btn_raw = 4'b0100;
        wait_press(2, 20, lat);
        chk_rng("rpt_press_lat", lat, 1, 16);
        p = t_prs[2];
        repeat (100) step();
        chk("rpt_count", {28'h0, n_rpt[2]}, 32'd5);
        for (int k = 0; k < 5; k++) begin
            $sformat(nm, "rpt_offset%0d", k);
            chk_rng(nm, (k < rpt_q.size()) ? rpt_q[k] - p : -1, 29 + 16 * k, 35 + 16 * k);
        end
        chk("rpt_level", {31'h0, level[2]}, 32'd1);
        btn_raw = 4'b0000;
        repeat (28) step();

        // Asynchronous reset while ch2 sits in RPT with the button still down.
        clear_counts();
        btn_raw = 4'b0100;
        wait_press(2, 20, lat);
        chk_rng("rst_pre_press_lat", lat, 1, 16);
        repeat (40) step();
        chk("rst_pre_repeat", {16'h0, n_rpt}, 32'h0100);
        rst_n = 1'b0;
        #2;
        chk("rst_async_outputs", {level, press_pulse, release_pulse, repeat_pulse}, 32'h0);
        repeat (3) step();
        rst_n = 1'b1;
        clear_counts();
        wait_press(2, 20, lat);
        chk_rng("rst_post_press_lat", lat, 1, 16);
        p = t_prs[2];
        for (int k = 0; k < 40 && rpt_q.size() == 0; k++) step();
        chk_rng("rst_post_first_rpt", (rpt_q.size() > 0) ? rpt_q[0] - p : -1, 29, 35);
        chk("rst_no_release", {16'h0, n_rel}, 32'h0);
        btn_raw = 4'b0000;
        repeat (28) step();

        // ch0 clean press alongside ch1 chattering, both starting together.
        clear_counts();
        s0 = cyc;
        for (int k = 0; k < 90; k++) begin
            btn_raw[0] = (k < 50);
            if (k < 30)      btn_raw[1] = k[0];
            else if (k < 50) btn_raw[1] = 1'b1;
            else if (k < 70) btn_raw[1] = k[0];
            else             btn_raw[1] = 1'b0;
            step();
        end
        chk("chat_press", {16'h0, n_prs}, 32'h0011);
        chk("chat_release", {16'h0, n_rel}, 32'h0011);
        chk("chat_other_rpt", {16'h0, n_rpt[3], n_rpt[2], 8'h0}, 32'h0);
        chk_rng("chat_ch0_press_lat", t_prs[0] - s0, 1, 16);
        chk_rng("chat_ch0_release_lat", t_rel[0] - (s0 + 50), 1, 16);
        btn_raw = 4'b0000;
        repeat (28) step();

        chk("pulse_width", wid_err, 32'd0);
        chk("pulse_overlap", ovl_err, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/btn_debouncer_multi.md
Name: btn_debouncer_multi

Overview:
- NCH-channel successor to the single-button debouncer.
- Per channel: 2-FF synchroniser, shared tick-based stable-sample filter, then clean level plus one-cycle press, release and auto-repeat pulses.
- Sits between board push-buttons and counter/menu logic.
- Auto-repeat while held generalises the single inc_pulse into a hold-to-increment function.

Parameters:
- NCH, 4: number of independent button channels (>=1).
- DIV, 8: clk cycles per sample tick (>=1; 1 = tick every cycle).
- N, 3: consecutive disagreeing ticks required to flip the debounced level (>=1).
- HOLD_TICKS, 64: ticks of continuous debounced press before the first repeat pulse (>=1).
- RPT_TICKS, 16: ticks between subsequent repeat pulses (>=1).
- ACTIVE_LOW, 0: 1 = btn_raw is 0 when pressed (inverted before the synchroniser).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_raw  in  NCH  asynchronous raw button inputs.
- repeat_en  in  NCH  per-channel auto-repeat enable, synchronous to clk.
- level  out  NCH  debounced level, 1 = pressed.
- press_pulse  out  NCH  one-cycle pulse on debounced 0->1.
- release_pulse  out  NCH  one-cycle pulse on debounced 1->0.
- repeat_pulse  out  NCH  one-cycle auto-repeat pulse.

Behaviour:
- Reset (rst_n=0, async): all outputs 0; sync flops, stable counters, hold counters and tick divider 0; every FSM in REL. Reset is honoured mid-operation with no pulse emitted on entry or exit.
- Polarity: p = ACTIVE_LOW ? ~btn_raw : btn_raw, then 2-FF sync per channel giving s[i].
- Tick divider: counts 0..DIV-1 and wraps. tick=1 for exactly one cycle when count==DIV-1. One divider is shared by all channels.
- Stable filter, per channel, evaluated only on tick:
  - s!=level: cnt+1.
  - s==level: cnt<=0.
  - When the increment would reach N, level toggles and cnt<=0.
  - cnt holds between ticks. cnt width is clog2(N+1).
- Pulse timing: press_pulse/release_pulse are registered and high in the same cycle level changes; they never last more than 1 cycle.
- Latency from a clean raw edge to pulse: 2 sync cycles + N ticks (+ up to DIV-1 tick-alignment cycles).
- A glitch lasting fewer than N ticks produces no level change and no pulse.
- Per-channel FSM:
  - REL: level=0. On press transition -> HOLD with hcnt<=0.
  - HOLD: on each tick hcnt+1. When hcnt reaches HOLD_TICKS: repeat_pulse for 1 cycle, hcnt<=0, -> RPT.
  - RPT: on each tick hcnt+1. When hcnt reaches RPT_TICKS: repeat_pulse, hcnt<=0.
  - Release transition from HOLD or RPT -> REL with hcnt<=0. release_pulse fires; no repeat_pulse is emitted that cycle.
  - repeat_en[i]=0 while in HOLD or RPT: hcnt held at 0, state forced to HOLD, no repeat pulses. Re-enabling restarts the full HOLD_TICKS delay.
  - hcnt width is clog2(max(HOLD_TICKS,RPT_TICKS)+1).
- press_pulse and repeat_pulse are never high together on one channel.
- Channels are fully independent. Pulses on different channels may coincide in the same cycle.

Decomposition:
- Package btn_pkg holds:
  - the FSM state enum (REL, HOLD, RPT);
  - width helper constants;
  - default parameter values shared with other button logic.
- One sub-module, btn_debounce_ch: sync + filter + FSM for a single channel, taking the shared tick as an input.
- The top level owns the tick divider and instantiates NCH copies via generate.

Test Plan:
All scenarios use NCH=4, DIV=4, N=3, HOLD_TICKS=8, RPT_TICKS=4, ACTIVE_LOW=0 and repeat_en=4'b1111 unless stated otherwise.

1. Clean press on ch0, held 40 cycles, then released:
   - exactly 1 press_pulse[0] within 16 cycles of the edge;
   - exactly 1 release_pulse[0] within 16 cycles of release;
   - level[0] high between the two pulses.
2. ch1 toggles btn_raw every clk for 30 cycles, then holds 1 for 20 cycles; later toggles for 20 cycles, then holds 0:
   - exactly 1 press_pulse[1] and 1 release_pulse[1];
   - no pulse longer than 1 cycle.
3. ch2 held pressed for 100 cycles after its press_pulse:
   - repeat_pulse[2] exactly 5 times, at press+32, +48, +64, +80 and +96 cycles (+/-3 cycles).
   - Repeat with repeat_en[2]=0: 0 repeat pulses.
4. ch3 raw high for 8 cycles (2 ticks) only:
   - level[3] stays 0;
   - no pulses on any output.
5. rst_n pulsed low for 3 cycles while ch2 is in RPT with btn_raw still high:
   - all outputs 0 immediately (async);
   - after release, a fresh press_pulse[2] within 16 cycles, then first repeat_pulse[2] 32 cycles later.
6. ch0 clean press and ch1 chattering press started in the same cycle:
   - each channel gives exactly 1 press_pulse;
   - ch0 unaffected by ch1;
   - no cross-channel pulses.
